mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-to-1 selection datapath between four requesters. It owns the 2-bit select, grants one requester at a time, and forwards the winner's data to a single downstream consumer over a valid/ready handshake. It sits in front of the 4:1 mux layer and is the only block that drives its select lines.

---
 rtl/mux_arb_pkg.sv | 27 ++
 rtl/arb_rr_pick.sv | 34 +++
 rtl/mux4.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_pkg
//  Brief    : Shared types and constants for the round-robin mux arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int NUM_REQ           = 4;
    localparam int SEL_W             = 2;
    localparam int MAX_BURST_DEFAULT = 4;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // One-hot vector with only bit idx set
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : arb_rr_pick
//  Brief    : Combinational round-robin picker; first set request at or after
//             ptr, wrapping 3 -> 0.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic [SEL_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins
    always_comb begin
        winner = ptr;
        any    = 1'b0;
        w_idx  = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ptr + SEL_W'(k);
            if (req[w_idx]) begin
                winner = w_idx;
                any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux4.sv
`default_nettype none
// ============================================================================
//  Module   : mux4
//  Brief    : Single-bit 4:1 multiplexer used in the shared selection layer.
//  Revision : 1.0 - initial release
// ============================================================================
module mux4 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] s,
    output logic       y
);

    // Plain select of one of four inputs
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arbiter
//  Brief    : Round-robin arbiter owning the 4:1 mux select; forwards the
//             granted requester's data over a valid/ready handshake.
//             Optional burst limit enabled by defining ARB_BURST_LIMIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [DATA_W-1:0]   din0,
    input  logic [DATA_W-1:0]   din1,
    input  logic [DATA_W-1:0]   din2,
    input  logic [DATA_W-1:0]   din3,
    output logic [NUM_REQ-1:0]  ack,
    output logic [NUM_REQ-1:0]  grant,
    output logic [SEL_W-1:0]    sel,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                busy
);

    generate
        if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
            $error("mux_rr_arbiter: MAX_BURST must be in 1..16");
        end
    endgenerate

    arb_state_t          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;

    logic [SEL_W-1:0]    w_winner;
    logic                w_any;
    logic                w_in_grant;
    logic                w_xfer;
    logic                w_burst_end;
    logic                w_release;

    arb_rr_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // Handshake is gated by state so nothing leaks out while idle or in reset
    assign w_in_grant = (r_state == ARB_GRANT);
    assign out_valid  = w_in_grant & req[r_sel];
    assign w_xfer     = out_valid & out_ready;
    assign ack        = w_xfer ? onehot(r_sel) : '0;
    assign w_release  = w_in_grant & (~req[r_sel] | w_burst_end);
    assign grant      = r_grant;
    assign sel        = r_sel;
    assign busy       = w_in_grant;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign w_burst_end = w_xfer & (r_cnt == CNT_W'(MAX_BURST - 1));

    // Beat counter: cleared on each new grant, advances only on accepted beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ARB_IDLE) begin
            r_cnt <= '0;
        end else if (w_xfer && !w_burst_end) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_burst_end = 1'b0;
`endif

    // Grant FSM: pick a winner from IDLE, hold it until release, then rotate ptr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state <= ARB_GRANT;
                        r_grant <= onehot(w_winner);
                        r_sel   <= w_winner;
                    end
                end
                ARB_GRANT: begin
                    if (w_release) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                        r_ptr   <= r_sel + SEL_W'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Shared 4:1 selection layer, one mux per data bit
    generate
        for (genvar b = 0; b < DATA_W; b++) begin : g_bit
            mux4 u_mux (
                .d0 (din0[b]),
                .d1 (din1[b]),
                .d2 (din2[b]),
                .d3 (din3[b]),
                .s  (r_sel),
                .y  (out_data[b])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_arbiter
//  Brief    : Directed self-checking bench for mux_rr_arbiter (DATA_W=4,
//             MAX_BURST=2). Burst-limit steps follow ARB_BURST_LIMIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din0, din1, din2, din3;
    logic [3:0] ack;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    mux_rr_arbiter #(
        .DATA_W    (4),
        .MAX_BURST (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .ack       (ack),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        din0 = 4'hA; din1 = 4'h5; din2 = 4'hC; din3 = 4'h3;
        tick(); #1;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_sel", sel, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_data", out_data, 4'hA);
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("idle_grant", grant, 4'b0000);
            chk("idle_valid", out_valid, 1'b0);
            chk("idle_sel", sel, 2'd0);
            chk("idle_busy", busy, 1'b0);
        end

        // Single requester 2
        req = 4'b0100; out_ready = 1'b1; #1;
        chk("single_pre_grant", grant, 4'b0000);
        tick(); #1;
        chk("single_grant", grant, 4'b0100);
        chk("single_sel", sel, 2'd2);
        chk("single_busy", busy, 1'b1);
        chk("single_ack1", ack, 4'b0100);
        chk("single_data", out_data, 4'hC);
        tick(); #1;
        chk("single_ack2", ack, 4'b0100);
        req = 4'b0000; #1;
        chk("single_drop_valid", out_valid, 1'b0);
        chk("single_drop_ack", ack, 4'b0000);
        tick(); #1;
        chk("single_rel_busy", busy, 1'b0);
        chk("single_rel_grant", grant, 4'b0000);
        // ptr must now be 3: with 0 and 3 requesting, 3 wins
        req = 4'b1001;
        tick(); #1;
        chk("ptr3_grant", grant, 4'b1000);
        chk("ptr3_sel", sel, 2'd3);
        chk("ptr3_data", out_data, 4'h3);
        req = 4'b0000;
        tick(); #1;
        chk("ptr3_rel_busy", busy, 1'b0);

        // Backpressure on requester 1 (ptr = 0)
        req = 4'b0010; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("bp_grant", grant, 4'b0010);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_ack", ack, 4'b0000);
        end
        out_ready = 1'b1; #1;
        chk("bp_ack_first", ack, 4'b0010);
        chk("bp_data", out_data, 4'h5);
        tick(); #1;
        chk("bp_ack_second", ack, 4'b0010);
        tick(); #1;
`ifdef ARB_BURST_LIMIT_EN
        chk("bp_burst_end_grant", grant, 4'b0000);
        chk("bp_burst_end_busy", busy, 1'b0);
`else
        chk("bp_held_grant", grant, 4'b0010);
        chk("bp_held_ack", ack, 4'b0010);
`endif
        req = 4'b0000;
        tick(); #1;
        chk("bp_idle_grant", grant, 4'b0000);
        chk("bp_idle_busy", busy, 1'b0);

        // Requester 3 alone: ptr goes from 2 to 0 after its release
        req = 4'b1000;
        tick(); #1;
        chk("r3_grant", grant, 4'b1000);
        req = 4'b0000;
        tick(); #1;
        chk("r3_rel_busy", busy, 1'b0);

`ifdef ARB_BURST_LIMIT_EN
        // All four requesting: 2 beats per grant, one idle cycle between owners
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("rr_grant", grant, 4'(1 << order[i]));
            chk("rr_ack1", ack, 4'(1 << order[i]));
            tick(); #1;
            chk("rr_ack2", ack, 4'(1 << order[i]));
            tick(); #1;
            chk("rr_gap_grant", grant, 4'b0000);
            chk("rr_gap_valid", out_valid, 1'b0);
        end
        req = 4'b0000;
        tick(); #1;
`else
        // Requester 0 holds the path while 3 waits
        req = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            chk("hold_grant", grant, 4'b0001);
            chk("hold_ack", ack, 4'b0001);
        end
        req = 4'b1000;
        tick(); #1;
        chk("hold_rel_grant", grant, 4'b0000);
        tick(); #1;
        chk("hold_next_grant", grant, 4'b1000);
        chk("hold_next_sel", sel, 2'd3);
        req = 4'b0000;
        tick(); #1;
`endif
        chk("pre_rst_busy", busy, 1'b0);

        // Asynchronous reset in the middle of a burst by requester 1
        req = 4'b0010;
        tick(); #1;
        chk("mid_grant", grant, 4'b0010);
        chk("mid_ack", ack, 4'b0010);
        rst = 1'b1; #1;
        chk("async_grant", grant, 4'b0000);
        chk("async_valid", out_valid, 1'b0);
        chk("async_ack", ack, 4'b0000);
        chk("async_busy", busy, 1'b0);
        chk("async_sel", sel, 2'd0);
        req = 4'b1111;
        tick();
        rst = 1'b0;
        tick(); #1;
        chk("post_rst_grant", grant, 4'b0001);
        chk("post_rst_data", out_data, 4'hA);
        req = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
